// File: rtl/alarm_pkg.sv
// ============================================================================
// Module      : alarm_pkg
// Description : Shared widths, state encoding and helpers for alarm_trigger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_sec_timer.sv
// ============================================================================
// Module      : alarm_sec_timer
// Description : Clearable 1 Hz tick counter; o_expired flags the tick that
//               brings the count up to i_limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_sec_timer #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_cnt_inc;

    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // Must not depend on i_clr: the owner derives i_clr from this flag.
    assign o_expired = i_tick & (w_cnt_inc == {1'b0, i_limit});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/alarm_trigger.sv
// ============================================================================
// Module      : alarm_trigger
// Description : Alarm match, ring/snooze/stop FSM and ring timeout; drives
//               o_play_music. Optional macro ALARM_SNOOZE_LIMIT_EN caps
//               snoozes per event at MAX_SNOOZE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = 300,
    parameter int SNOOZE_S       = 540,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick_1hz,
    input  logic [HOUR_W-1:0] i_cur_hour,
    input  logic [MIN_W-1:0]  i_cur_min,
    input  logic [SEC_W-1:0]  i_cur_sec,
    input  logic [HOUR_W-1:0] i_alarm_hour,
    input  logic [MIN_W-1:0]  i_alarm_min,
    input  logic              i_alarm_en,
    input  logic              i_snooze_btn,
    input  logic              i_stop_btn,
    output logic              o_play_music,
    output logic              o_snoozing,
    output logic [1:0]        o_snooze_cnt
);

    localparam int               c_CNT_W    = $clog2(max_int(RING_TIMEOUT_S, SNOOZE_S) + 1);
    localparam logic [c_CNT_W-1:0] c_RING_LIM = c_CNT_W'(RING_TIMEOUT_S);
    localparam logic [c_CNT_W-1:0] c_SNZ_LIM  = c_CNT_W'(SNOOZE_S);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               r_play;
    logic               r_snoozing;
    logic [1:0]         r_snooze_cnt;
    logic               w_play_d;
    logic               w_snoozing_d;
    logic [1:0]         w_snooze_cnt_d;
    logic               w_match;
    logic               w_snooze_ok;
    logic               w_expired;
    logic               w_clr;
    logic [c_CNT_W-1:0] w_limit;

    assign w_match = i_tick_1hz & i_alarm_en
                   & (i_cur_hour == i_alarm_hour)
                   & (i_cur_min  == i_alarm_min)
                   & (i_cur_sec  == '0);

`ifdef ALARM_SNOOZE_LIMIT_EN
    assign w_snooze_ok = (32'(r_snooze_cnt) != MAX_SNOOZE);
`else
    assign w_snooze_ok = 1'b1;
`endif

    // Counter restarts on every state change so each period starts from zero.
    assign w_clr   = (r_state == ST_IDLE) | (w_next != r_state);
    assign w_limit = (r_state == ST_SNOOZE) ? c_SNZ_LIM : c_RING_LIM;

    alarm_sec_timer #(
        .CNT_W (c_CNT_W)
    ) u_sec_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_tick    (i_tick_1hz),
        .i_limit   (w_limit),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_play       <= 1'b0;
            r_snoozing   <= 1'b0;
            r_snooze_cnt <= 2'd0;
        end else begin
            r_state      <= w_next;
            r_play       <= w_play_d;
            r_snoozing   <= w_snoozing_d;
            r_snooze_cnt <= w_snooze_cnt_d;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_match) w_next = ST_RING;
            end
            ST_RING: begin
                if (!i_alarm_en)                      w_next = ST_IDLE;
                else if (i_stop_btn)                  w_next = ST_IDLE;
                else if (i_snooze_btn && w_snooze_ok) w_next = ST_SNOOZE;
                else if (w_expired)                   w_next = ST_IDLE;
            end
            ST_SNOOZE: begin
                if (!i_alarm_en)     w_next = ST_IDLE;
                else if (i_stop_btn) w_next = ST_IDLE;
                else if (w_expired)  w_next = ST_RING;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_play_d       = (w_next == ST_RING);
        w_snoozing_d   = (w_next == ST_SNOOZE);
        w_snooze_cnt_d = r_snooze_cnt;
        if (w_next == ST_IDLE || r_state == ST_IDLE) begin
            w_snooze_cnt_d = 2'd0;
        end else if (r_state == ST_RING && w_next == ST_SNOOZE) begin
            w_snooze_cnt_d = (r_snooze_cnt == 2'd3) ? 2'd3 : r_snooze_cnt + 2'd1;
        end
    end

    assign o_play_music = r_play;
    assign o_snoozing   = r_snoozing;
    assign o_snooze_cnt = r_snooze_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alarm_trigger.sv
// ============================================================================
// Module      : tb_alarm_trigger
// Description : Self-checking bench for alarm_trigger: directed vector table,
//               async-reset sequence and randomized run against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_trigger;

    localparam int R = 5;
    localparam int S = 3;
    localparam int M = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic [4:0] ah;
    logic [5:0] am;
    logic       en;
    logic       snz;
    logic       stp;
    wire        play;
    wire        snoozing;
    wire  [1:0] cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle / 1 ringing / 2 snoozing, ticks left in period.
    int m_mode = 0;
    int m_left = 0;
    int m_snz  = 0;

    typedef struct {
        bit       t;
        bit [5:0] s;
        bit [5:0] mi;
        bit       e;
        bit       sz;
        bit       sp;
        bit       x_play;
        bit       x_snoozing;
        bit [1:0] x_cnt;
    } vec_t;

    vec_t vecs[$];

    alarm_trigger #(
        .RING_TIMEOUT_S (R),
        .SNOOZE_S       (S),
        .MAX_SNOOZE     (M)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_tick_1hz   (tick),
        .i_cur_hour   (hh),
        .i_cur_min    (mm),
        .i_cur_sec    (ss),
        .i_alarm_hour (ah),
        .i_alarm_min  (am),
        .i_alarm_en   (en),
        .i_snooze_btn (snz),
        .i_stop_btn   (stp),
        .o_play_music (play),
        .o_snoozing   (snoozing),
        .o_snooze_cnt (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit allowed;
`ifdef ALARM_SNOOZE_LIMIT_EN
        allowed = (m_snz < M);
`else
        allowed = 1'b1;
`endif
        if (!en) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (tick && hh == ah && mm == am && ss == 0) begin
                m_mode = 1;
                m_left = R;
            end
        end else if (m_mode == 1) begin
            if (stp) m_mode = 0;
            else if (snz && allowed) begin
                m_mode = 2;
                m_left = S;
                m_snz  = (m_snz >= 3) ? 3 : m_snz + 1;
            end else if (tick) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end else begin
            if (stp) m_mode = 0;
            else if (tick) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 1;
                    m_left = R;
                end
            end
        end
        if (m_mode == 0) m_snz = 0;
    endtask

    task automatic step(input bit t, input int h, input int mi, input int s,
                        input bit e, input bit sz, input bit sp);
        tick = t;
        hh   = h[4:0];
        mm   = mi[5:0];
        ss   = s[5:0];
        en   = e;
        snz  = sz;
        stp  = sp;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".play"},     32'(play),     32'(m_mode == 1));
        check({tag, ".snoozing"}, 32'(snoozing), 32'(m_mode == 2));
        check({tag, ".cnt"},      32'(cnt),      32'(m_snz));
    endtask

    function automatic vec_t mk(bit t, int s, int mi, bit e, bit sz, bit sp,
                                bit p, bit z, int c);
        vec_t v;
        v.t = t; v.s = s[5:0]; v.mi = mi[5:0]; v.e = e; v.sz = sz; v.sp = sp;
        v.x_play = p; v.x_snoozing = z; v.x_cnt = c[1:0];
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        tick = 0; hh = 0; mm = 0; ss = 0; en = 0; snz = 0; stp = 0;
        ah = 5'd7; am = 6'd30;

        // Alarm 07:30, RING=5 ticks, SNOOZE=3 ticks.
        vecs.push_back(mk(0, 0, 30, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 30, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 30, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 31, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 30, 1, 0, 0, 1, 0, 0));
        for (int i = 1; i <= 4; i++) vecs.push_back(mk(1, i, 30, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 5, 30, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 30, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 6, 30, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 7, 30, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 8, 30, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 9, 30, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 9, 30, 1, 1, 0, 0, 1, 2));
        vecs.push_back(mk(1, 10, 30, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 11, 30, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 12, 30, 1, 0, 0, 1, 0, 2));
`ifdef ALARM_SNOOZE_LIMIT_EN
        vecs.push_back(mk(0, 12, 30, 1, 1, 0, 1, 0, 2));
`else
        vecs.push_back(mk(0, 12, 30, 1, 1, 0, 0, 1, 3));
`endif
        vecs.push_back(mk(0, 13, 30, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 30, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 30, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 30, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 30, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 30, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 30, 1, 0, 0, 1, 0, 0));
        for (int i = 1; i <= 4; i++) vecs.push_back(mk(1, i, 30, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 5, 30, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 6, 30, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 7, 30, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 8, 30, 1, 0, 0, 1, 0, 1));
        for (int i = 9; i <= 12; i++) vecs.push_back(mk(1, i, 30, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 13, 30, 1, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        check("reset.play",     32'(play),     32'd0);
        check("reset.snoozing", 32'(snoozing), 32'd0);
        check("reset.cnt",      32'(cnt),      32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].t, 7, vecs[i].mi, vecs[i].s, vecs[i].e, vecs[i].sz, vecs[i].sp);
            check($sformatf("vec%0d.play", i),     32'(play),     32'(vecs[i].x_play));
            check($sformatf("vec%0d.snoozing", i), 32'(snoozing), 32'(vecs[i].x_snoozing));
            check($sformatf("vec%0d.cnt", i),      32'(cnt),      32'(vecs[i].x_cnt));
        end

        // Asynchronous reset in the middle of ringing.
        step(1, 7, 30, 0, 1, 0, 0);
        check("rst_mid.ring", 32'(play), 32'd1);
        step(1, 7, 30, 1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.play_async", 32'(play), 32'd0);
        check("rst_mid.cnt",        32'(cnt),  32'd0);
        m_mode = 0; m_left = 0; m_snz = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 7, 30, 10, 1, 0, 0);
        check("rst_after.no_ring", 32'(play), 32'd0);
        step(1, 7, 30, 0, 1, 0, 0);
        check("rst_after.next_match", 32'(play), 32'd1);
        step(0, 7, 30, 1, 1, 0, 1);
        check_model("rst_after.stop");

        for (int n = 0; n < 800; n++) begin
            int h, mi, s;
            h  = ($urandom % 4 == 0) ? int'($urandom_range(0, 23)) : 7;
            mi = ($urandom % 4 == 0) ? int'($urandom_range(0, 59)) : 30;
            s  = ($urandom % 3 == 0) ? int'($urandom_range(1, 59)) : 0;
            step(bit'($urandom % 2), h, mi, s, bit'($urandom % 40 != 0),
                 bit'($urandom % 5 == 0), bit'($urandom % 25 == 0));
            check_model($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alarm_trigger.md
# alarm_trigger

Decides when the alarm sounds and drives `play_music` into the tone generator. It compares the running clock time against the stored alarm time once per second. It runs the ring / snooze / stop state machine and enforces the ring timeout. It sits between the timekeeping/settings logic and the song player.

## Interface
Parameters:
- `RING_TIMEOUT_S`, 300: seconds of continuous ringing before auto-stop.
- `SNOOZE_S`, 540: seconds spent in snooze before re-ringing.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event (only with `ALARM_SNOOZE_LIMIT_EN`).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_1hz` in 1: one-cycle pulse, once per second.
- `cur_hour` in 5: current hour, 0–23.
- `cur_min` in 6: current minute, 0–59.
- `cur_sec` in 6: current second, 0–59.
- `alarm_hour` in 5: alarm hour.
- `alarm_min` in 6: alarm minute.
- `alarm_en` in 1: alarm armed, level.
- `snooze_btn` in 1: debounced one-cycle pulse.
- `stop_btn` in 1: debounced one-cycle pulse.
- `play_music` out 1: high while ringing; feeds the song player.
- `snoozing` out 1: high in the snooze state.
- `snooze_cnt` out 2: snoozes taken in the current event.

## Operation
- States: IDLE, RING, SNOOZE. All outputs are registered.
- Match condition: `tick_1hz & alarm_en & cur_hour==alarm_hour & cur_min==alarm_min & cur_sec==0`.
  - Because of the `cur_sec==0` term, it fires at most once per minute.
- IDLE -> RING on match. Clear the seconds counter and `snooze_cnt`.
- RING:
  - `stop_btn` -> IDLE.
  - Else `snooze_btn` (if allowed) -> SNOOZE. Increment `snooze_cnt` (saturating at 3) and clear the seconds counter.
  - Else on `tick_1hz`, count seconds. Reaching `RING_TIMEOUT_S` -> IDLE.
- SNOOZE:
  - `stop_btn` -> IDLE.
  - Else on `tick_1hz`, count seconds. Reaching `SNOOZE_S` -> RING and clear the counter.
  - `snooze_btn` is ignored.
- Priority: `alarm_en`=0 > `stop_btn` > `snooze_btn` > timer expiry. A match in RING or SNOOZE is ignored.
- `alarm_en` deasserted in any state -> IDLE on the next edge. The counter and `snooze_cnt` clear.
- Entering IDLE from any state clears `snooze_cnt`.
- Seconds counter: width `$clog2(max(RING_TIMEOUT_S, SNOOZE_S)+1)`, unsigned. It never wraps, because it is compared for equality and cleared on every state change.
- `snooze_cnt` holds its value through RING/SNOOZE cycles and clears only in IDLE.

## Timing
- Reset (`rst_n`=0, async): state IDLE, `play_music`=0, `snoozing`=0, `snooze_cnt`=0, counter 0.
- Match on edge N -> `play_music`=1 after edge N (one-cycle latency).
- Button pulse on edge N -> output change visible after edge N.
- Timeouts: the transition occurs on the edge of the `tick_1hz` cycle that brings the counter to the limit. RING lasts exactly `RING_TIMEOUT_S` ticks; SNOOZE lasts `SNOOZE_S` ticks.
- `stop_btn` and `snooze_btn` in the same cycle: stop wins.
- A button coincident with the expiry tick: the button wins. Example: snooze on the last RING tick -> SNOOZE, not IDLE.
- Reset mid-RING: `play_music` drops asynchronously.

## Configuration
- `ALARM_SNOOZE_LIMIT_EN` defined:
  - `snooze_btn` in RING is ignored once `snooze_cnt==MAX_SNOOZE`.
  - Ringing continues until stop or timeout.
- Not defined:
  - Snooze is unlimited.
  - `snooze_cnt` saturates at 3 for display only.
  - `MAX_SNOOZE` is unused.

## Structure
- Package `alarm_pkg`:
  - State encoding constants `ST_IDLE`/`ST_RING`/`ST_SNOOZE` (2 bits).
  - `HOUR_W`=5, `MIN_W`=6, `SEC_W`=6.
- One sub-module, `alarm_sec_timer`:
  - Clearable tick counter with `clr`, `tick`, `limit`, and an `expired` output.
  - Shared between RING and SNOOZE.

## Test plan
All scenarios use `RING_TIMEOUT_S`=5, `SNOOZE_S`=3, `MAX_SNOOZE`=2.
- Alarm 07:30, time 07:30:00 with tick -> `play_music`=1 next cycle; after 5 more ticks, `play_music`=0 and state IDLE.
- Ringing, `snooze_btn` -> `snoozing`=1, `play_music`=0, `snooze_cnt`=1; after 3 ticks, `play_music`=1 again.
- `ALARM_SNOOZE_LIMIT_EN`: two snoozes taken, third `snooze_btn` -> stays RING, `snooze_cnt`=2. Without the macro, it goes to SNOOZE with `snooze_cnt`=3.
- `stop_btn` and `snooze_btn` in the same cycle while ringing -> IDLE, `snooze_cnt`=0.
- `alarm_en`=0 during SNOOZE -> IDLE next edge. Match at 07:30:01 or with `alarm_en`=0 -> no ring.
- `rst_n` low mid-RING -> `play_music`=0 immediately. After release, no ring until the next matching minute.
